rf_wr_packer: RTL

RF_WR_PACKER -- requirements
Module: rf_wr_packer

---
 rtl/rf_wr_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rf_wr_packer.sv
// rf_wr_packer
//   Packs a stream of bytes into memory words and writes them to the port B
//   of a register file. A run begins with start_i and ends with the byte
//   that carries pix_last_i. Each word is written once it is full, or
//   earlier if it holds the last byte of the run. Unused lanes of a partial
//   word are masked off through wenb_o.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start_i      one-cycle pulse that begins a run (IDLE only)
//   base_addr_i  first word address of the run, sampled with start_i
//   pix_valid_i  byte on pix_i is valid
//   pix_i        byte data
//   pix_last_i   final byte of the run, qualified by pix_valid_i
//   pix_ready_o  a byte is accepted this cycle when valid (PACK only)
//   cenb_o       RF chip enable, low active, low for one cycle per write
//   wenb_o       RF per-byte write enable, low active
//   addrb_o      RF word address, holds the last written value
//   datab_o      RF write data, holds the last written value
//   done_o       pulse that coincides with the final write of a run
//   word_cnt_o   words written in the current or last run
module rf_wr_packer #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8,
  parameter int Byte_Width = Word_Width >> 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [Addr_Width-1:0] base_addr_i,
  input  logic                  pix_valid_i,
  input  logic [7:0]            pix_i,
  input  logic                  pix_last_i,
  output logic                  pix_ready_o,
  output logic                  cenb_o,
  output logic [Byte_Width-1:0] wenb_o,
  output logic [Addr_Width-1:0] addrb_o,
  output logic [Word_Width-1:0] datab_o,
  output logic                  done_o,
  output logic [Addr_Width:0]   word_cnt_o
);

  localparam int LaneW = (Byte_Width > 1) ? $clog2(Byte_Width) : 1;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t                state_reg, state_next;
  logic [LaneW-1:0]      lane_reg;
  logic [Byte_Width-1:0] mask_reg;
  logic [Word_Width-1:0] data_reg;
  logic [Addr_Width-1:0] addr_cnt_reg;

  logic                  accept;
  logic                  complete;
  logic [Byte_Width-1:0] mask_ins;
  logic [Word_Width-1:0] data_ins;

  assign accept   = (state_reg == PACK) && pix_valid_i;
  assign complete = accept &&
                    ((lane_reg == LaneW'(Byte_Width - 1)) || pix_last_i);

  // Staging word with the byte being accepted merged in. When the word is
  // completed by this byte, these merged values go straight to the RF port,
  // which is what lets PACK run at one byte per cycle without stalling.
  generate
    for (genvar gi = 0; gi < Byte_Width; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit           = accept && (lane_reg == LaneW'(gi));
      assign mask_ins[gi]       = lane_hit ? 1'b0 : mask_reg[gi];
      assign data_ins[8*gi +: 8] = lane_hit ? pix_i : data_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pix_ready_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = PACK;
        end
      end
      PACK: begin
        pix_ready_o = 1'b1;
        if (accept && pix_last_i) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // The final write is on the port during this cycle.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_reg     <= '0;
      mask_reg     <= '1;
      data_reg     <= '0;
      addr_cnt_reg <= '0;
      cenb_o       <= 1'b1;
      wenb_o       <= '1;
      addrb_o      <= '0;
      datab_o      <= '0;
      done_o       <= 1'b0;
      word_cnt_o   <= '0;
    end else begin
      // Port idles by default; a write lasts exactly one cycle.
      cenb_o <= 1'b1;
      wenb_o <= '1;
      done_o <= 1'b0;
      if ((state_reg == IDLE) && start_i) begin
        lane_reg     <= '0;
        mask_reg     <= '1;
        data_reg     <= '0;
        addr_cnt_reg <= base_addr_i;
        word_cnt_o   <= '0;
      end else if (complete) begin
        cenb_o       <= 1'b0;
        wenb_o       <= mask_ins;
        addrb_o      <= addr_cnt_reg;
        datab_o      <= data_ins;
        done_o       <= pix_last_i;
        lane_reg     <= '0;
        mask_reg     <= '1;
        data_reg     <= '0;
        addr_cnt_reg <= addr_cnt_reg + Addr_Width'(1);
        word_cnt_o   <= word_cnt_o + (Addr_Width + 1)'(1);
      end else if (accept) begin
        lane_reg <= lane_reg + LaneW'(1);
        mask_reg <= mask_ins;
        data_reg <= data_ins;
      end
    end
  end

endmodule
